// File: rtl/dp_ctxt_rdstream_pkg.sv
// Shared constants and helpers for the ciphertext polyvec read-stream stage.
//   DP_MAX_N_SPLIT        number of URAM split groups in the polyvec bank
//   DP_COMMON_URAM_DELAY  URAM read latency in cycles (>= 1)
//   popcount32()          number of set bits in a 32-bit vector
package dp_ctxt_rdstream_pkg;

    localparam int unsigned DP_MAX_N_SPLIT       = 4;
    localparam int unsigned DP_COMMON_URAM_DELAY = 2;

    function automatic int unsigned popcount32(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dp_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy count.
//   clk, rst        clock, asynchronous active-high reset (flushes pointers/flags)
//   push_i, din_i   write request and data; accepted when not full or when popping
//   pop_i, dout_o   read request; dout_o shows the head entry (valid when !empty_o)
//   count_o         current occupancy, 0..DEPTH
//   full_o, empty_o registered status flags
module dp_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the pointers and flags define what is live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/dp_ctxt_rdstream.sv
// Read-side streaming stage for the ciphertext polyvec URAM bank.
// Walks base..base+len-1 (mod 2^ADDR_WIDTH) on the selected split group, absorbs the
// fixed URAM latency with a tag shift register and emits words on a valid/ready stream.
//   clk, rst                      clock, asynchronous active-high reset
//   i_rd_start/base/len/idx_split start request (ignored while busy) and its operands
//   o_rd_busy, o_rd_done          busy level and one-cycle completion pulse
//   o_uram_mem_en, o_uram_rdaddr  one-hot URAM enable and read address
//   i_uram_dout                   URAM read data, COMMON_URAM_DELAY after the address
//   o_valid/i_ready/o_data/o_last output stream; o_data[0 +: DW/2] is ctxt0
module dp_ctxt_rdstream
    import dp_ctxt_rdstream_pkg::*;
#(
    parameter int unsigned COE_WIDTH         = 35,
    parameter int unsigned ADDR_WIDTH        = 12,
    parameter int unsigned NUM_POLY          = 3,
    parameter int unsigned NUM_SPLIT         = DP_MAX_N_SPLIT,
    parameter int unsigned COMMON_URAM_DELAY = DP_COMMON_URAM_DELAY,
    parameter int unsigned FIFO_DEPTH        = 8,
    localparam int unsigned DW               = NUM_POLY * COE_WIDTH * 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_start,
    input  logic [ADDR_WIDTH-1:0] i_rd_base,
    input  logic [ADDR_WIDTH:0]   i_rd_len,
    input  logic [1:0]            i_idx_split,
    output logic                  o_rd_busy,
    output logic                  o_rd_done,
    output logic [NUM_SPLIT-1:0]  o_uram_mem_en,
    output logic [ADDR_WIDTH-1:0] o_uram_rdaddr,
    input  logic [DW-1:0]         i_uram_dout,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DW-1:0]         o_data,
    output logic                  o_last
);

    localparam int unsigned D  = COMMON_URAM_DELAY;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [1:0]            split_q, split_d;
    logic [D-1:0]          vld_sr_q, vld_sr_d;
    logic [D-1:0]          last_sr_q, last_sr_d;
    logic                  done_q, done_d;

    logic                  issue, last_issue, credit_ok, hs;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [DW:0]           fifo_dout;

    // Every tag in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_ok  = !fifo_full &&
                        ((popcount32(32'(vld_sr_q)) + 32'(fifo_count)) < FIFO_DEPTH);
    assign issue      = (state_q == S_ISSUE) && credit_ok;
    assign last_issue = (cnt_q == len_q - LEN_ONE);
    assign hs         = o_valid && i_ready;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        split_d = split_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_rd_start) begin
                    base_d  = i_rd_base;
                    len_d   = i_rd_len;
                    split_d = i_idx_split;
                    cnt_d   = '0;
                    if (i_rd_len == '0) done_d = 1'b1;
                    else                state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    cnt_d = cnt_q + LEN_ONE;
                    if (last_issue) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hs && o_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tags travel alongside the URAM access; the exiting tag marks i_uram_dout as live.
    always_comb begin
        vld_sr_d     = '0;
        last_sr_d    = '0;
        vld_sr_d[0]  = issue;
        last_sr_d[0] = issue && last_issue;
        for (int i = 1; i < int'(D); i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            split_q   <= '0;
            vld_sr_q  <= '0;
            last_sr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            split_q   <= split_d;
            vld_sr_q  <= vld_sr_d;
            last_sr_q <= last_sr_d;
            done_q    <= done_d;
        end
    end

    dp_sync_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (vld_sr_q[D-1]),
        .pop_i   (hs),
        .din_i   ({last_sr_q[D-1], i_uram_dout}),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        o_uram_mem_en = '0;
        for (int i = 0; i < int'(NUM_SPLIT); i++) begin
            o_uram_mem_en[i] = issue && (split_q == 2'(i));
        end
    end

    // Address wraps naturally in ADDR_WIDTH bits.
    assign o_uram_rdaddr = (state_q == S_ISSUE) ? base_q + cnt_q[ADDR_WIDTH-1:0] : '0;
    assign o_rd_busy     = (state_q != S_IDLE);
    assign o_rd_done     = done_q;
    assign o_valid       = !fifo_empty;
    // Gate with valid so stale storage never leaks onto the stream.
    assign o_last        = o_valid && fifo_dout[DW];
    assign o_data        = o_valid ? fifo_dout[DW-1:0] : '0;

endmodule

// File: tb/tb_dp_ctxt_rdstream.sv
// Scoreboard bench for dp_ctxt_rdstream: stimulus pushes expected addresses and words,
// a negedge monitor pops and compares whenever the DUT issues or hands off a word.
module tb_dp_ctxt_rdstream;
    import dp_ctxt_rdstream_pkg::*;

    localparam int unsigned COE_WIDTH  = 35;
    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned NUM_POLY   = 3;
    localparam int unsigned NUM_SPLIT  = DP_MAX_N_SPLIT;
    localparam int unsigned D          = DP_COMMON_URAM_DELAY;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DW         = NUM_POLY * COE_WIDTH * 2;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_rd_start = 1'b0;
    logic [ADDR_WIDTH-1:0] i_rd_base = '0;
    logic [ADDR_WIDTH:0]   i_rd_len = '0;
    logic [1:0]            i_idx_split = '0;
    logic                  o_rd_busy, o_rd_done;
    logic [NUM_SPLIT-1:0]  o_uram_mem_en;
    logic [ADDR_WIDTH-1:0] o_uram_rdaddr;
    logic [DW-1:0]         i_uram_dout;
    logic                  o_valid, o_last;
    logic                  i_ready = 1'b1;
    logic [DW-1:0]         o_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ready_mode = 0;
    int start_cyc, first_valid_cyc, first_issue_cyc, last_hs_cyc, done_cyc;
    int issued = 0, hs_total = 0, done_cnt = 0, out_cnt = 0;
    logic                  prev_stall = 1'b0;
    logic [DW+1:0]         prev_word = '0;
    logic [NUM_SPLIT-1:0]  en_exp = '0;
    exp_t                  exp_q[$];
    logic [ADDR_WIDTH-1:0] addr_q[$];
    logic [ADDR_WIDTH-1:0] upipe[D];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dp_ctxt_rdstream #(
        .COE_WIDTH         (COE_WIDTH),
        .ADDR_WIDTH        (ADDR_WIDTH),
        .NUM_POLY          (NUM_POLY),
        .NUM_SPLIT         (NUM_SPLIT),
        .COMMON_URAM_DELAY (D),
        .FIFO_DEPTH        (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rd_start    (i_rd_start),
        .i_rd_base     (i_rd_base),
        .i_rd_len      (i_rd_len),
        .i_idx_split   (i_idx_split),
        .o_rd_busy     (o_rd_busy),
        .o_rd_done     (o_rd_done),
        .o_uram_mem_en (o_uram_mem_en),
        .o_uram_rdaddr (o_uram_rdaddr),
        .i_uram_dout   (i_uram_dout),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_last        (o_last)
    );

    // URAM content: address-derived so order and half placement are both visible.
    function automatic logic [DW-1:0] uram_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        w[ADDR_WIDTH-1:0]      = a;
        w[DW/2 +: ADDR_WIDTH]  = ~a;
        w[DW-1 -: ADDR_WIDTH]  = a ^ 12'h5A5;
        return w;
    endfunction

    // URAM model: fixed read latency D, keeps running through reset.
    always @(posedge clk) begin
        upipe[0] <= o_uram_rdaddr;
        for (int i = 1; i < int'(D); i++) upipe[i] <= upipe[i-1];
    end
    assign i_uram_dout = uram_word(upipe[D-1]);

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) i_ready = 1'b1;
        else                 i_ready = ((cyc % 4) == 3);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %s expected nothing (cycle %0d)", name, what, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_uram_mem_en != '0) begin
                issued++;
                out_cnt++;
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                if (addr_q.size() == 0) begin
                    flag("unexpected_issue", $sformatf("addr %0h", o_uram_rdaddr));
                end else begin
                    chk("rdaddr", 256'(o_uram_rdaddr), 256'(addr_q.pop_front()));
                    chk("mem_en", 256'(o_uram_mem_en), 256'(en_exp));
                end
            end
            if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) chk("stall_hold", 256'({o_valid, o_last, o_data}), 256'(prev_word));
            if (o_valid && i_ready) begin
                hs_total++;
                out_cnt--;
                if (exp_q.size() == 0) begin
                    flag("unexpected_word", $sformatf("data %0h", o_data));
                end else begin
                    chk("word", 256'({o_last, o_data}), 256'(exp_q.pop_front()));
                end
                if (o_last) last_hs_cyc = cyc;
            end
            if (o_rd_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ready_mode == 1) chk("credit_le_depth", 256'(out_cnt <= int'(FIFO_DEPTH)), 256'(1));
            prev_stall = o_valid && !i_ready;
            prev_word  = {o_valid, o_last, o_data};
        end else begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end
    end

    task automatic start_rd(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] len,
                            input logic [1:0] split, input bit accept);
        logic [ADDR_WIDTH-1:0] a;
        exp_t e;
        @(posedge clk);
        #1;
        i_rd_start  = 1'b1;
        i_rd_base   = base;
        i_rd_len    = len;
        i_idx_split = split;
        if (accept) begin
            start_cyc       = cyc;
            first_valid_cyc = -1;
            first_issue_cyc = -1;
            en_exp          = NUM_SPLIT'(1) << split;
            for (int k = 0; k < int'(len); k++) begin
                a      = base + ADDR_WIDTH'(k);
                e.last = (k == int'(len) - 1);
                e.data = uram_word(a);
                addr_q.push_back(a);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        i_rd_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_rd_done && n < budget);
        vectors++;
        if (!o_rd_done) begin
            miscompares++;
            $display("FAIL %s_done_timeout: got no done expected done within %0d cycles", name,
                     budget);
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by time 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, i0, h0, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 256'(o_valid), 256'(0));
        chk("rst_busy", 256'(o_rd_busy), 256'(0));
        chk("rst_mem_en", 256'(o_uram_mem_en), 256'(0));
        rst = 1'b0;

        // Basic stream: base 0, len 16, split 1, full throughput.
        d0 = done_cnt; i0 = issued;
        start_rd(12'h000, 13'd16, 2'd1, 1'b1);
        wait_done("basic", 100);
        chk("basic_first_issue", 256'(first_issue_cyc), 256'(start_cyc + 1));
        chk("basic_first_valid", 256'(first_valid_cyc), 256'(start_cyc + int'(D) + 2));
        chk("basic_last_word", 256'(last_hs_cyc), 256'(start_cyc + int'(D) + 17));
        chk("basic_done_cyc", 256'(done_cyc), 256'(start_cyc + int'(D) + 18));
        chk("basic_busy_at_done", 256'(o_rd_busy), 256'(0));
        chk("basic_issued", 256'(issued - i0), 256'(16));
        chk("basic_done_cnt", 256'(done_cnt - d0), 256'(1));
        chk("basic_drained", 256'(exp_q.size()), 256'(0));

        // Wrap-around: 0xFFE, 0xFFF, 0x000, 0x001.
        start_rd(12'hFFE, 13'd4, 2'd2, 1'b1);
        wait_done("wrap", 100);
        chk("wrap_drained", 256'(exp_q.size() + addr_q.size()), 256'(0));

        // Backpressure: 3 low / 1 high.
        h0 = hs_total;
        ready_mode = 1;
        start_rd(12'h100, 13'd32, 2'd3, 1'b1);
        wait_done("backpressure", 400);
        ready_mode = 0;
        chk("bp_words", 256'(hs_total - h0), 256'(32));
        chk("bp_drained", 256'(exp_q.size()), 256'(0));

        // Zero length: done on the next cycle, nothing issued.
        d0 = done_cnt; i0 = issued;
        start_rd(12'h123, 13'd0, 2'd0, 1'b1);
        chk("zero_done_pulse", 256'(o_rd_done), 256'(1));
        chk("zero_busy", 256'(o_rd_busy), 256'(0));
        repeat (4) @(negedge clk);
        #1;
        chk("zero_no_issue", 256'(issued - i0), 256'(0));
        chk("zero_done_cnt", 256'(done_cnt - d0), 256'(1));

        // Start while busy is dropped.
        d0 = done_cnt; i0 = issued; h0 = hs_total;
        start_rd(12'h040, 13'd8, 2'd0, 1'b1);
        @(posedge clk);
        start_rd(12'h800, 13'd5, 2'd1, 1'b0);
        wait_done("busy_start", 100);
        repeat (10) @(negedge clk);
        #1;
        chk("busy_done_cnt", 256'(done_cnt - d0), 256'(1));
        chk("busy_issued", 256'(issued - i0), 256'(8));
        chk("busy_words", 256'(hs_total - h0), 256'(8));

        // Reset after five handshakes of a len=20 read.
        h0 = hs_total;
        start_rd(12'h200, 13'd20, 2'd1, 1'b1);
        n = 0;
        while (hs_total < h0 + 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reached5", 256'(hs_total - h0 >= 5), 256'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 256'(o_valid), 256'(0));
        chk("rst_mid_last", 256'(o_last), 256'(0));
        chk("rst_mid_data", 256'(o_data), 256'(0));
        chk("rst_mid_busy", 256'(o_rd_busy), 256'(0));
        chk("rst_mid_done", 256'(o_rd_done), 256'(0));
        chk("rst_mid_mem_en", 256'(o_uram_mem_en), 256'(0));
        chk("rst_mid_addr", 256'(o_uram_rdaddr), 256'(0));
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        h0 = hs_total;
        repeat (2 * int'(D) + 6) @(negedge clk);
        #1;
        chk("rst_no_stale_words", 256'(hs_total - h0), 256'(0));
        chk("rst_idle_valid", 256'(o_valid), 256'(0));

        d0 = done_cnt;
        start_rd(12'h300, 13'd3, 2'd2, 1'b1);
        wait_done("post_rst", 100);
        chk("post_rst_words", 256'(hs_total - h0), 256'(3));
        chk("post_rst_done_cnt", 256'(done_cnt - d0), 256'(1));
        chk("final_exp_empty", 256'(exp_q.size() + addr_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
